mips_dmem_responder: RTL and testbench

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

---
 rtl/mips_dmem_responder.sv | 77 +++++++
 tb/tb_mips_dmem_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: MIPS data-memory responder with word RAM, LED, cycle counter
// and a 4-entry TX byte FIFO behind memory-mapped registers at 0xFFFFFF00..0C.
module mips_dmem_responder #(
   parameter int RAM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwriteM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic [15:0] led,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);
   localparam int AW = $clog2(RAM_WORDS);
   logic [31:0] ram_q [RAM_WORDS];
   logic [7:0]  fifo_q [4];
   logic [15:0] led_q, led_d;
   logic [31:0] cyc_q, cyc_d;
   logic [1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        in_ram, mmio, sel_led, sel_cyc, sel_tx, sel_st, wr, full, pop, push;
   logic [AW-1:0] idx;
   logic        unused_addr;
   assign unused_addr = ^aluoutM[1:0];
   assign in_ram  = aluoutM[31:AW+2] == '0;
   assign idx     = aluoutM[AW+1:2];
   assign mmio    = aluoutM[31:4] == 28'hFFFFFF0;
   assign sel_led = mmio && aluoutM[3:2] == 2'd0;
   assign sel_cyc = mmio && aluoutM[3:2] == 2'd1;
   assign sel_tx  = mmio && aluoutM[3:2] == 2'd2;
   assign sel_st  = mmio && aluoutM[3:2] == 2'd3;
   assign wr      = memwriteM & ~reset;
   assign full    = cnt_q == 3'd4;
   assign tx_valid = cnt_q != 3'd0;
   assign tx_data  = fifo_q[rd_q];
   assign led      = led_q;
   assign pop  = tx_valid & tx_ready & ~reset;
   // A full FIFO still accepts a store when the head leaves in the same cycle.
   assign push = wr & sel_tx & (~full | pop);
   always_comb begin
      led_d = wr && sel_led ? writedataM[15:0] : led_q;
      cyc_d = wr && sel_cyc ? 32'd0 : cyc_q + 32'd1;
      rd_d  = pop ? rd_q + 2'd1 : rd_q;
      wr_d  = push ? wr_q + 2'd1 : wr_q;
      cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
      ovf_d = (wr & sel_tx & full & ~pop) | (ovf_q & ~(wr & sel_st & writedataM[4]));
      readdataM = in_ram  ? ram_q[idx] :
                  sel_led ? {16'b0, led_q} :
                  sel_cyc ? cyc_q :
                  sel_st  ? {27'b0, ovf_q, full, cnt_q} : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= '0;
         cyc_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         led_q <= led_d;
         cyc_q <= cyc_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr && in_ram) ram_q[idx] <= writedataM;
      if (push) fifo_q[wr_q] <= writedataM[7:0];
   end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed stimulus with a scoreboard; loads and TX bytes
// are queued as expectations and checked by an independent negedge monitor.
module tb_mips_dmem_responder;
   localparam logic [31:0] A_LED = 32'hFFFFFF00, A_CYC = 32'hFFFFFF04,
                           A_TX = 32'hFFFFFF08, A_ST = 32'hFFFFFF0C;
   logic        clk = 0, reset = 1, memwriteM = 0, tx_ready = 0, tx_valid, rd_chk = 0;
   logic [31:0] aluoutM = 0, writedataM = 0, readdataM;
   logic [15:0] led;
   logic [7:0]  tx_data;
   logic [31:0] exp_rd[$];
   string       exp_nm[$];
   logic [7:0]  exp_tx[$];
   int          n_chk = 0, n_fail = 0;

   mips_dmem_responder #(.RAM_WORDS(64)) dut (
      .clk(clk), .reset(reset), .memwriteM(memwriteM), .aluoutM(aluoutM),
      .writedataM(writedataM), .readdataM(readdataM), .led(led),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_chk) begin
         if (exp_rd.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
         else chk(exp_nm.pop_front(), readdataM, exp_rd.pop_front());
      end
      if (!reset && tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) chk("tx_unexpected_byte", {24'b0, tx_data}, 32'hFFFFFFFF);
         else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
      end
   end

   task automatic step();
      @(posedge clk); #1;
      memwriteM = 0;
      rd_chk = 0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwriteM = 1; aluoutM = a; writedataM = d;
      step();
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] e, input string nm);
      aluoutM = a; rd_chk = 1;
      exp_rd.push_back(e); exp_nm.push_back(nm);
      step();
   endtask

   task automatic tx_push(input logic [7:0] b, input bit expect_out);
      if (expect_out) exp_tx.push_back(b);
      store(A_TX, {24'b0, b});
   endtask

   task automatic drain();
      tx_ready = 1;
      for (int i = 0; i < 12 && exp_tx.size() != 0; i++) step();
      chk("drain_done", exp_tx.size(), 0);
      step();
      tx_ready = 0;
      chk("tx_valid_after_drain", {31'b0, tx_valid}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      step();
      reset = 0;
      chk("reset_led", {16'b0, led}, 0);
      chk("reset_tx_valid", {31'b0, tx_valid}, 0);
      load(A_CYC, 0, "cycle_after_reset");
      repeat (4) step();
      load(A_CYC, 5, "cycle_5");
      store(A_CYC, 32'h1234);
      load(A_CYC, 0, "cycle_cleared");
      load(A_CYC, 1, "cycle_incr");
      load(A_ST, 0, "status_reset");
      store(32'h10, 32'hDEADBEEF);
      load(32'h10, 32'hDEADBEEF, "ram_read");
      aluoutM = 32'h10; writedataM = 32'h12345678; memwriteM = 1; rd_chk = 1;
      exp_rd.push_back(32'hDEADBEEF); exp_nm.push_back("ram_old_in_store_cycle");
      step();
      load(32'h13, 32'h12345678, "ram_low_bits_ignored");
      store(32'hFC, 32'hCAFEF00D);
      load(32'hFC, 32'hCAFEF00D, "ram_top_word");
      store(32'h110, 32'h0BADF00D);
      load(32'h110, 0, "unmapped_past_ram");
      load(32'h10, 32'h12345678, "ram_no_alias");
      store(A_LED, 32'h0001ABCD);
      chk("led_out", {16'b0, led}, 32'hABCD);
      load(A_LED, 32'h0000ABCD, "led_read");
      load(32'h1000, 0, "unmapped_1000");
      for (int i = 0; i < 5; i++) tx_push(8'h41 + 8'(i), i < 4);
      load(A_TX, 0, "txdata_read_zero");
      load(A_ST, 32'h1C, "status_overflow_full");
      drain();
      load(A_ST, 32'h10, "status_sticky_ovf");
      store(A_ST, 32'h10);
      load(A_ST, 0, "status_ovf_cleared");
      for (int i = 0; i < 4; i++) tx_push(8'h61 + 8'(i), 1);
      chk("tx_valid_full", {31'b0, tx_valid}, 1);
      tx_ready = 1;
      tx_push(8'h55, 1);
      tx_ready = 0;
      load(A_ST, 32'h0C, "status_full_push_pop");
      drain();
      for (int i = 0; i < 3; i++) tx_push(8'h71 + 8'(i), 0);
      load(A_ST, 32'h03, "status_three_queued");
      reset = 1; tx_ready = 1;
      memwriteM = 1; aluoutM = 32'h10; writedataM = 32'h0;
      step();
      reset = 0; tx_ready = 0;
      chk("mid_reset_tx_valid", {31'b0, tx_valid}, 0);
      chk("mid_reset_led", {16'b0, led}, 0);
      load(A_ST, 0, "mid_reset_status");
      load(32'h10, 32'h12345678, "ram_kept_over_reset");
      step();
      chk("scoreboard_rd_empty", exp_rd.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
